multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle datapath: fetch, decode, execute, memory and writeback run as FSM states, one per cycle.
- Instruction memory and data memory sit outside the block behind ports; data memory uses a req/ack handshake with wait states.
- 8-entry register file with r0 hardwired to zero, fixed 16-bit instruction encoding, parametrised data width and address widths.

---
 rtl/multicycle_core.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_core.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB core with 8-entry register file
module multicycle_core #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    input  logic               dmem_ack,
    output logic               halted,
    output logic               retire,
    output logic               illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [DATA_W-1:0]   rf_q [8];
    logic [DATA_W-1:0]   rf_d [8];

    logic [3:0]          op;
    logic [2:0]          rd, funct;
    logic [DATA_W-1:0]   imm_data, alu_out;
    logic [31:0]         imm_s32;
    logic [PC_W-1:0]     pc_inc, pc_br, pc_jmp;
    logic [2:0]          dec_b_idx;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[11:9];
    assign funct     = ir_q[2:0];
    assign imm_data  = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
    assign imm_s32   = {{26{ir_q[5]}}, ir_q[5:0]};
    assign pc_inc    = pc_q + PC_W'(1);
    assign pc_br     = PC_W'(32'(pc_inc) + imm_s32);
    assign pc_jmp    = PC_W'(ir_q[11:0]);
    // R-type reads rt as second operand; branches and stores read rd instead
    assign dec_b_idx = (imem_rdata[15:12] == OP_R) ? imem_rdata[5:3] : imem_rdata[11:9];

    // memory port is only live in MEM, so reset (which forces FETCH) drops it without a clock
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = dmem_req && (op == OP_SW);
    assign dmem_addr  = dmem_req ? DMEM_AW'(res_q) : '0;
    assign dmem_wdata = dmem_req ? b_q : '0;
    assign halted     = (state_q == S_HALT);

    // ALU for register-register operations; shift amount is the low nibble of rt
    always_comb begin
        alu_out = '0;
        case (funct)
            3'd0: alu_out = a_q + b_q;
            3'd1: alu_out = a_q - b_q;
            3'd2: alu_out = a_q & b_q;
            3'd3: alu_out = a_q | b_q;
            3'd4: alu_out = a_q ^ b_q;
            3'd5: alu_out = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            3'd6: alu_out = a_q << b_q[3:0];
            default: alu_out = a_q >> b_q[3:0];
        endcase
    end

    // next-state, datapath updates and single-cycle status pulses
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        rf_d    = rf_q;
        retire  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = imem_rdata;
                a_d     = rf_q[imem_rdata[8:6]];
                b_d     = rf_q[dec_b_idx];
                illegal = imem_rdata[15];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d = pc_inc;
                case (op)
                    OP_R: begin
                        res_d   = alu_out;
                        state_d = S_WB;
                    end
                    OP_ADDI: begin
                        res_d   = a_q + imm_data;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        res_d   = a_q + imm_data;
                        state_d = S_MEM;
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = pc_br;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_BNE: begin
                        if (a_q != b_q) pc_d = pc_br;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = pc_jmp;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_LW) begin
                        res_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                if (rd != 3'd0) rf_d[rd] = res_q;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rf_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rf_q    <= rf_d;
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// tb/tb_multicycle_core.sv - scoreboard bench for multicycle_core against an ISA-level model
module tb_multicycle_core;
    localparam int DATA_W  = 16;
    localparam int PC_W    = 8;
    localparam int DMEM_AW = 8;

    logic               clk;
    logic               reset;
    logic [PC_W-1:0]    imem_addr;
    logic [15:0]        imem_rdata;
    logic               dmem_req, dmem_we, dmem_ack;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata, dmem_rdata;
    logic               halted, retire, illegal;

    multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .halted(halted), .retire(retire), .illegal(illegal)
    );

    typedef struct { logic [PC_W-1:0] next_pc; int base; int ill; bit halt; } ret_t;
    typedef struct { bit we; logic [DMEM_AW-1:0] addr; logic [DATA_W-1:0] wdata; } mem_t;

    ret_t              ret_q[$];
    mem_t              mem_q[$];
    logic [15:0]       imem  [256];
    logic [DATA_W-1:0] dmem  [256];
    logic [DATA_W-1:0] dinit [256];
    int  errors = 0, checks = 0;
    int  wait_acc = 0, forced_wait = -1;
    bit  ack_en = 1'b1, mon_en = 1'b0, halt_seen = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [15:0] enc_r(input logic [2:0] f, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {4'd0, rd, rs, rt, f};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input int imm);
        return {op, rd, rs, 6'(imm)};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
    endtask

    // ISA-level interpreter: walks the program and queues every expected retirement and memory access
    task automatic build_model();
        logic [DATA_W-1:0]  r [8];
        logic [DATA_W-1:0]  m [256];
        logic [PC_W-1:0]    pc;
        logic [15:0]        w;
        logic [DATA_W-1:0]  vs, vd, vt, res;
        logic [DMEM_AW-1:0] ad;
        int                 simm;
        bit                 done;
        ret_q.delete();
        mem_q.delete();
        for (int i = 0; i < 8; i++) r[i] = '0;
        for (int i = 0; i < 256; i++) m[i] = dinit[i];
        pc   = '0;
        done = 1'b0;
        for (int n = 0; n < 4000 && !done; n++) begin
            w    = imem[pc];
            vs   = r[w[8:6]];
            vd   = r[w[11:9]];
            vt   = r[w[5:3]];
            simm = $signed(w[5:0]);
            ad   = DMEM_AW'(vs + DATA_W'(simm));
            res  = '0;
            case (w[15:12])
                4'd0: begin
                    case (w[2:0])
                        3'd0: res = vs + vt;
                        3'd1: res = vs - vt;
                        3'd2: res = vs & vt;
                        3'd3: res = vs | vt;
                        3'd4: res = vs ^ vt;
                        3'd5: res = ($signed(vs) < $signed(vt)) ? DATA_W'(1) : '0;
                        3'd6: res = vs << vt[3:0];
                        default: res = vs >> vt[3:0];
                    endcase
                    if (w[11:9] != 3'd0) r[w[11:9]] = res;
                    ret_q.push_back('{next_pc: PC_W'(pc + 1), base: 4, ill: 0, halt: 1'b0});
                    pc = PC_W'(pc + 1);
                end
                4'd1: begin
                    if (w[11:9] != 3'd0) r[w[11:9]] = vs + DATA_W'(simm);
                    ret_q.push_back('{next_pc: PC_W'(pc + 1), base: 4, ill: 0, halt: 1'b0});
                    pc = PC_W'(pc + 1);
                end
                4'd2: begin
                    mem_q.push_back('{we: 1'b0, addr: ad, wdata: '0});
                    if (w[11:9] != 3'd0) r[w[11:9]] = m[ad];
                    ret_q.push_back('{next_pc: PC_W'(pc + 1), base: 5, ill: 0, halt: 1'b0});
                    pc = PC_W'(pc + 1);
                end
                4'd3: begin
                    mem_q.push_back('{we: 1'b1, addr: ad, wdata: vd});
                    m[ad] = vd;
                    ret_q.push_back('{next_pc: PC_W'(pc + 1), base: 4, ill: 0, halt: 1'b0});
                    pc = PC_W'(pc + 1);
                end
                4'd4, 4'd5: begin
                    if ((vd == vs) == (w[15:12] == 4'd4)) pc = PC_W'(int'(pc) + 1 + simm);
                    else pc = PC_W'(pc + 1);
                    ret_q.push_back('{next_pc: pc, base: 3, ill: 0, halt: 1'b0});
                end
                4'd6: begin
                    pc = PC_W'(w[11:0]);
                    ret_q.push_back('{next_pc: pc, base: 3, ill: 0, halt: 1'b0});
                end
                4'd7: begin
                    ret_q.push_back('{next_pc: '0, base: 3, ill: 0, halt: 1'b1});
                    done = 1'b1;
                end
                default: begin
                    ret_q.push_back('{next_pc: PC_W'(pc + 1), base: 3, ill: 1, halt: 1'b0});
                    pc = PC_W'(pc + 1);
                end
            endcase
        end
    endtask

    // instruction memory: address captured at the edge, data appears for the following cycle
    initial begin
        logic [PC_W-1:0] a;
        imem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            a = imem_addr;
            #1 imem_rdata = imem[a];
        end
    end

    // data memory responder with wait states and stray acks while idle
    initial begin
        int wait_left;
        bit in_txn;
        wait_left  = 0;
        in_txn     = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_ack   = 1'b0;
            dmem_rdata = DATA_W'($urandom);
            if (!dmem_req) begin
                in_txn   = 1'b0;
                dmem_ack = ($urandom_range(0, 3) == 0);
            end else if (ack_en) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    wait_left = (forced_wait >= 0) ? forced_wait : int'($urandom_range(0, 2));
                end
                if (wait_left == 0) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = dmem[dmem_addr];
                    if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                    in_txn = 1'b0;
                end else begin
                    wait_left--;
                    wait_acc++;
                end
            end
        end
    end

    // monitor: pops the scoreboard on each memory completion and each retirement
    initial begin
        int          cyc, ill;
        bit          chk_next, chk_halt;
        logic [PC_W-1:0] exp_pc;
        ret_t        re;
        mem_t        me;
        cyc = 0; ill = 0; chk_next = 1'b0; chk_halt = 1'b0; exp_pc = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                cyc = 0; ill = 0; chk_next = 1'b0; chk_halt = 1'b0;
            end else begin
                cyc++;
                if (chk_next) begin
                    chk("next_pc", 32'(imem_addr), 32'(exp_pc));
                    chk_next = 1'b0;
                end
                if (chk_halt) begin
                    chk("halted", 32'(halted), 32'd1);
                    chk_halt = 1'b0;
                end
                if (illegal) ill++;
                if (dmem_req && dmem_ack) begin
                    if (mem_q.size() == 0) fail("unexpected_dmem_access");
                    else begin
                        me = mem_q.pop_front();
                        chk("dmem_we", 32'(dmem_we), 32'(me.we));
                        chk("dmem_addr", 32'(dmem_addr), 32'(me.addr));
                        if (me.we) chk("dmem_wdata", 32'(dmem_wdata), 32'(me.wdata));
                    end
                end
                if (retire) begin
                    if (ret_q.size() == 0) fail("unexpected_retire");
                    else begin
                        re = ret_q.pop_front();
                        chk("latency", 32'(cyc), 32'(re.base + wait_acc));
                        chk("illegal_pulses", 32'(ill), 32'(re.ill));
                        if (re.halt) begin
                            chk_halt  = 1'b1;
                            halt_seen = 1'b1;
                        end else begin
                            chk_next = 1'b1;
                            exp_pc   = re.next_pc;
                        end
                    end
                    cyc = 0; ill = 0; wait_acc = 0;
                end
            end
        end
    end

    task automatic run_prog(input int fw, input int max_cyc);
        int n;
        bit quiet;
        logic [PC_W-1:0] hold;
        forced_wait = fw;
        ack_en      = 1'b1;
        mon_en      = 1'b0;
        halt_seen   = 1'b0;
        build_model();
        for (int i = 0; i < 256; i++) dmem[i] = dinit[i];
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_imem_addr", 32'(imem_addr), 32'd0);
        chk("reset_outputs", {28'd0, dmem_req, halted, retire, illegal}, 32'd0);
        @(posedge clk);
        #1;
        wait_acc = 0;
        reset    = 1'b1;
        mon_en   = 1'b1;
        n = 0;
        while (!(halt_seen && ret_q.size() == 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) fail("timeout_waiting_for_halt");
        @(negedge clk);
        @(negedge clk);
        hold  = imem_addr;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (imem_addr !== hold || dmem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1)
                quiet = 1'b0;
        end
        chk("halt_quiet", 32'(quiet), 32'd1);
        chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        mon_en = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        case ($urandom_range(0, 9))
            0, 1, 2: w = enc_r(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            3, 4, 9: w = enc_i(4'd1, 3'($urandom), 3'($urandom), int'($urandom_range(0, 63)));
            5:       w = enc_i(4'd2, 3'($urandom), 3'($urandom), int'($urandom_range(0, 63)));
            6:       w = enc_i(4'd3, 3'($urandom), 3'($urandom), int'($urandom_range(0, 63)));
            7:       w = enc_i(4'($urandom_range(4, 5)), 3'($urandom), 3'($urandom),
                           int'($urandom_range(0, 3)));
            default: w = {4'($urandom_range(8, 15)), 12'($urandom)};
        endcase
        return w;
    endfunction

    initial begin
        int n;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dinit[i] = DATA_W'($urandom);

        // arithmetic, r0 handling, SLT/SUB corners, store/load with 3 wait states
        clear_imem();
        imem[0]  = enc_i(4'd1, 3'd1, 3'd0, 5);
        imem[1]  = enc_r(3'd0, 3'd2, 3'd1, 3'd1);
        imem[2]  = enc_i(4'd3, 3'd2, 3'd0, 3);
        imem[3]  = enc_i(4'd2, 3'd3, 3'd0, 3);
        imem[4]  = enc_i(4'd3, 3'd3, 3'd0, 4);
        imem[5]  = enc_i(4'd1, 3'd0, 3'd0, 7);
        imem[6]  = enc_r(3'd0, 3'd4, 3'd0, 3'd0);
        imem[7]  = enc_i(4'd3, 3'd4, 3'd0, 5);
        imem[8]  = enc_i(4'd1, 3'd5, 3'd0, -1);
        imem[9]  = enc_i(4'd1, 3'd6, 3'd0, 1);
        imem[10] = enc_r(3'd5, 3'd7, 3'd5, 3'd6);
        imem[11] = enc_i(4'd3, 3'd7, 3'd0, 6);
        imem[12] = enc_r(3'd1, 3'd7, 3'd0, 3'd6);
        imem[13] = enc_i(4'd3, 3'd7, 3'd0, 7);
        run_prog(3, 500);

        // branches, JMP to top of PC space with wrap, illegal opcode
        clear_imem();
        imem[0]   = enc_i(4'd5, 3'd7, 3'd0, 4);
        imem[1]   = enc_i(4'd1, 3'd7, 3'd0, 1);
        imem[2]   = 16'h60FF;
        imem[4]   = 16'h6006;
        imem[5]   = enc_i(4'd4, 3'd1, 3'd1, -2);
        imem[6]   = enc_i(4'd5, 3'd1, 3'd1, 5);
        imem[7]   = 16'hAE3F;
        imem[8]   = enc_i(4'd3, 3'd7, 3'd0, 9);
        imem[255] = 16'hF000;
        run_prog(-1, 500);

        // reset asserted while a store is stalled in MEM
        clear_imem();
        imem[0] = enc_i(4'd1, 3'd1, 3'd0, 9);
        imem[1] = enc_i(4'd3, 3'd1, 3'd0, 5);
        mon_en  = 1'b0;
        ack_en  = 1'b0;
        reset   = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        n = 0;
        while (dmem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_mem_stall", 32'(dmem_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_req_drop", 32'(dmem_req), 32'd0);
        chk("async_pc_clear", 32'(imem_addr), 32'd0);

        // registers must read zero after that reset
        clear_imem();
        for (int k = 1; k < 8; k++) imem[k-1] = enc_i(4'd3, 3'(k), 3'd0, k);
        run_prog(-1, 500);

        // randomized straight-line programs with forward branches
        for (int t = 0; t < 4; t++) begin
            clear_imem();
            for (int i = 0; i < 40; i++) imem[i] = rand_instr();
            for (int i = 0; i < 256; i++) dinit[i] = DATA_W'($urandom);
            run_prog(-1, 3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
